// File: rtl/popcount_seq_pkg.sv
// Shared definitions for the sequential population counter:
// the FSM state encoding and a constant clog2 helper used for port and register sizing.
package popcount_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Ceiling log2, returns 0 for an argument of 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/popcnt_chunk.sv
// Combinational population count of one CHUNK-bit slice.
// The result is just wide enough to hold CHUNK.
module popcnt_chunk
    import popcount_seq_pkg::*;
#(
    parameter int CHUNK = 16,
    localparam int CW = clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CW-1:0]    count
);

    // Sum the individual bits of the slice.
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcount_seq.sv
// Sequential population counter with valid/ready handshakes on both sides.
// A captured word is counted CHUNK bits per cycle through a single popcnt_chunk
// instance, and the registered total is held until the consumer takes it.
// Optional feature: define POPCOUNT_THRESH_EN to add the thresh input and the
// out_ge compare output (out_count >= threshold captured with the word).
module popcount_seq
    import popcount_seq_pkg::*;
#(
    parameter int WIDTH = 255,
    parameter int CHUNK = 16,
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int OUT_W  = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_count,
`ifdef POPCOUNT_THRESH_EN
    input  logic [OUT_W-1:0] thresh,
    output logic             out_ge,
`endif
    output logic             busy
);

    // The captured word is zero-padded up to a whole number of chunks, so the
    // last chunk's bits above WIDTH contribute nothing to the count.
    localparam int PAD_W = NCHUNK * CHUNK;
    localparam int CW    = clog2(CHUNK + 1);
    localparam int IDX_W = (NCHUNK > 1) ? clog2(NCHUNK) : 1;

    state_t             state;
    logic [PAD_W-1:0]   data_q;
    logic [IDX_W-1:0]   idx;
    logic [OUT_W-1:0]   acc;
    logic [CHUNK-1:0]   chunk_bits;
    logic [CW-1:0]      chunk_cnt;
    logic [OUT_W-1:0]   sum;
    logic               last_chunk;
`ifdef POPCOUNT_THRESH_EN
    logic [OUT_W-1:0]   thresh_q;
`endif

    // Select the chunk addressed by idx for the shared chunk counter.
    always_comb begin
        chunk_bits = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDX_W'(i)) begin
                chunk_bits = data_q[i*CHUNK +: CHUNK];
            end
        end
    end

    popcnt_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .bits  (chunk_bits),
        .count (chunk_cnt)
    );

    // Running total including the current chunk; it cannot exceed WIDTH, so OUT_W bits never overflow.
    always_comb begin
        sum        = acc + OUT_W'(chunk_cnt);
        last_chunk = (idx == IDX_W'(NCHUNK - 1));
    end

    // Control FSM with registered handshake outputs, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            data_q    <= '0;
`ifdef POPCOUNT_THRESH_EN
            thresh_q  <= '0;
            out_ge    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q   <= PAD_W'(in_data);
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= COUNT;
`ifdef POPCOUNT_THRESH_EN
                        thresh_q <= thresh;
`endif
                    end
                end
                COUNT: begin
                    acc <= sum;
                    if (last_chunk) begin
                        idx       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_count <= sum;
                        state     <= DONE;
`ifdef POPCOUNT_THRESH_EN
                        out_ge    <= (sum >= thresh_q);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq: a table of directed words, randomized
// words against a $countones reference, reset abort, and two extra builds
// (WIDTH=8/CHUNK=3 and CHUNK=255).
module tb_popcount_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;

    // Default build: WIDTH=255, CHUNK=16.
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [254:0] in_data;
    logic [7:0]   out_count;

    // Small build: WIDTH=8, CHUNK=3.
    logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]   in_data8;
    logic [3:0]   out_count8;

    // Single-chunk build: WIDTH=255, CHUNK=255.
    logic         in_validw, in_readyw, out_validw, out_readyw, busyw;
    logic [254:0] in_dataw;
    logic [7:0]   out_countw;

`ifdef POPCOUNT_THRESH_EN
    logic [7:0]   thresh;
    logic         out_ge;
    logic [3:0]   thresh8 = '0;
    logic         out_ge8;
    logic [7:0]   threshw = '0;
    logic         out_gew;
`endif

    int checks = 0;
    int errors = 0;

    popcount_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
`ifdef POPCOUNT_THRESH_EN
        .thresh    (thresh),
        .out_ge    (out_ge),
`endif
        .busy      (busy)
    );

    popcount_seq #(.WIDTH(8), .CHUNK(3)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_count (out_count8),
`ifdef POPCOUNT_THRESH_EN
        .thresh    (thresh8),
        .out_ge    (out_ge8),
`endif
        .busy      (busy8)
    );

    popcount_seq #(.WIDTH(255), .CHUNK(255)) dutw (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_validw),
        .in_ready  (in_readyw),
        .in_data   (in_dataw),
        .out_valid (out_validw),
        .out_ready (out_readyw),
        .out_count (out_countw),
`ifdef POPCOUNT_THRESH_EN
        .thresh    (threshw),
        .out_ge    (out_gew),
`endif
        .busy      (busyw)
    );

    typedef struct {
        logic [254:0] data;
        int           expCount;
        int           hold;
        bit           earlyReady;
        bit           keepValid;
    } vec_t;

    vec_t vecs[6];

    // Reference: the number of ones in the word.
    function automatic int refCount(input logic [254:0] w);
        return $countones(w);
    endfunction

    function automatic logic [254:0] randWord();
        logic [254:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r = (r << 32) | 255'($urandom);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Offer one word to the default build, wait for its result and retire it.
    task automatic applyStimulus(input string name, input logic [254:0] w, input int expCount,
                                 input int hold, input bit earlyReady, input bit keepValid);
        int lat;
        bit seen;
        @(negedge clk);
        checkOutput({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_data   = w;
        in_valid  = 1'b1;
        out_ready = earlyReady;
`ifdef POPCOUNT_THRESH_EN
        thresh = 8'($urandom_range(0, 255));
`endif
        @(posedge clk);
        @(negedge clk);
        if (!keepValid) in_valid = 1'b0;
        in_data = randWord();
        checkOutput({name, "_busy"}, 32'(busy), 32'd1);
        checkOutput({name, "_in_ready_count"}, 32'(in_ready), 32'd0);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        in_valid = 1'b0;
        if (!seen) begin
            checkOutput({name, "_timeout"}, 32'd0, 32'd1);
            out_ready = 1'b0;
            return;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd16);
        checkOutput({name, "_count"}, 32'(out_count), 32'(expCount));
        checkOutput({name, "_busy_done"}, 32'(busy), 32'd0);
`ifdef POPCOUNT_THRESH_EN
        checkOutput({name, "_ge"}, 32'(out_ge), 32'(expCount >= int'(thresh)));
`endif
        if (!earlyReady) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                checkOutput({name, "_hold_valid"}, 32'(out_valid), 32'd1);
                checkOutput({name, "_hold_count"}, 32'(out_count), 32'(expCount));
                checkOutput({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput({name, "_retire_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, "_retire_in_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    // One word through the WIDTH=8, CHUNK=3 build.
    task automatic run8(input string name, input logic [7:0] w, input int expCount);
        int lat;
        @(negedge clk);
        in_data8  = w;
        in_valid8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (out_valid8 !== 1'b1 && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd3);
        checkOutput({name, "_count"}, 32'(out_count8), 32'(expCount));
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        checkOutput({name, "_in_ready"}, 32'(in_ready8), 32'd1);
    endtask

    // One word through the single-chunk build.
    task automatic runWide(input string name, input logic [254:0] w);
        int lat;
        @(negedge clk);
        in_dataw  = w;
        in_validw = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_validw = 1'b0;
        lat = 0;
        while (out_validw !== 1'b1 && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd1);
        checkOutput({name, "_count"}, 32'(out_countw), 32'(refCount(w)));
        out_readyw = 1'b1;
        @(negedge clk);
        out_readyw = 1'b0;
    endtask

    initial begin
        logic [254:0] tmp;
        bit sawValid;

        rst = 1'b1;
        in_valid = 1'b0;  out_ready = 1'b0;  in_data = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; in_data8 = '0;
        in_validw = 1'b0; out_readyw = 1'b0; in_dataw = '0;
`ifdef POPCOUNT_THRESH_EN
        thresh = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_count", 32'(out_count), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        vecs[0] = '{255'd0, 0, 0, 1'b1, 1'b0};
        vecs[1] = '{{255{1'b1}}, 255, 5, 1'b0, 1'b0};
        tmp = '0; tmp[254] = 1'b1;
        vecs[2] = '{tmp, 1, 1, 1'b0, 1'b0};
        tmp = '0;
        for (int i = 0; i < 255; i += 2) tmp[i] = 1'b1;
        vecs[3] = '{tmp, 128, 0, 1'b0, 1'b0};
        tmp = '0; tmp[0] = 1'b1;
        vecs[4] = '{tmp, 1, 2, 1'b0, 1'b1};
        tmp = '0;
        for (int i = 240; i < 255; i++) tmp[i] = 1'b1;
        vecs[5] = '{tmp, 15, 2, 1'b0, 1'b0};

        for (int v = 0; v < 6; v++) begin
            applyStimulus($sformatf("vec%0d", v), vecs[v].data, vecs[v].expCount,
                          vecs[v].hold, vecs[v].earlyReady, vecs[v].keepValid);
        end

        for (int r = 0; r < 25; r++) begin
            tmp = randWord();
            applyStimulus($sformatf("rand%0d", r), tmp, refCount(tmp),
                          int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        // Abort a word with reset while idx is 7.
        @(negedge clk);
        in_data  = {255{1'b1}};
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_out_count", 32'(out_count), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        sawValid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) sawValid = 1'b1;
        end
        checkOutput("abort_no_pulse", 32'(sawValid), 32'd0);
        tmp = '0;
        for (int i = 0; i < 255; i += 3) tmp[i] = 1'b1;
        applyStimulus("after_abort", tmp, 85, 1, 1'b0, 1'b0);

        run8("w8_ff", 8'hFF, 8);
        run8("w8_a5", 8'hA5, 4);
        run8("w8_80", 8'h80, 1);

        runWide("wide_ones", {255{1'b1}});
        for (int r = 0; r < 4; r++) begin
            runWide($sformatf("wide_rand%0d", r), randWord());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
